// File: rtl/development_stage_tracker.sv
// Debounces the raw development stage over tick samples, holds the confirmed
// stage with a saturating dwell count, and reports each change as one event.
module development_stage_tracker #(
  parameter int CONFIRM_TICKS = 4,
  parameter int DWELL_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [1:0]         development_stage,
  input  logic               evt_ready,
  output logic [1:0]         stage,
  output logic [DWELL_W-1:0] dwell,
  output logic               evt_valid,
  output logic               evt_advance,
  output logic [1:0]         evt_from,
  output logic [1:0]         evt_to,
  output logic               evt_overrun
);

  // Event handshake: a transfer happens on any clk edge with evt_valid and
  // evt_ready both high; fields hold while evt_valid is high until that
  // transfer, or until a newer commit overwrites them (flagged by evt_overrun).

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_CONFIRM = 1'b1
  } fsm_e;

  typedef struct packed {
    fsm_e       fsm;
    logic [1:0] cand;
    logic [3:0] cnt;
  } track_t;

  localparam logic [3:0]         CT        = 4'(CONFIRM_TICKS);
  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

  track_t             trk_q, trk_d;
  logic               commit;
  logic [1:0]         commit_to;

  logic [1:0]         stage_d;
  logic [DWELL_W-1:0] dwell_d;
  logic               evt_valid_d, evt_advance_d, evt_overrun_d;
  logic [1:0]         evt_from_d, evt_to_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_q <= '{fsm: ST_STABLE, cand: 2'd0, cnt: 4'd0};
    end else begin
      trk_q <= trk_d;
    end
  end

  // Next-state logic; commit marks the edge where a new stage is accepted
  always_comb begin
    trk_d     = trk_q;
    commit    = 1'b0;
    commit_to = trk_q.cand;
    if (tick) begin
      case (trk_q.fsm)
        ST_STABLE: begin
          if (development_stage != stage) begin
            trk_d.cand = development_stage;
            if (CT == 4'd1) begin
              commit    = 1'b1;
              commit_to = development_stage;
            end else begin
              trk_d.fsm = ST_CONFIRM;
              trk_d.cnt = 4'd1;
            end
          end
        end
        ST_CONFIRM: begin
          if (development_stage == trk_q.cand) begin
            if (trk_q.cnt + 4'd1 == CT) begin
              commit    = 1'b1;
              commit_to = trk_q.cand;
              trk_d.fsm = ST_STABLE;
              trk_d.cnt = 4'd0;
            end else begin
              trk_d.cnt = trk_q.cnt + 4'd1;
            end
          end else if (development_stage == stage) begin
            trk_d.fsm = ST_STABLE;
            trk_d.cnt = 4'd0;
          end else begin
            trk_d.cand = development_stage;
            trk_d.cnt  = 4'd1;
          end
        end
        default: begin
          trk_d = '{fsm: ST_STABLE, cand: 2'd0, cnt: 4'd0};
        end
      endcase
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    stage_d       = stage;
    dwell_d       = dwell;
    evt_valid_d   = evt_valid;
    evt_advance_d = evt_advance;
    evt_from_d    = evt_from;
    evt_to_d      = evt_to;
    evt_overrun_d = evt_overrun;

    if (tick) begin
      if (commit) begin
        dwell_d = '0;
      end else if (dwell != DWELL_MAX) begin
        dwell_d = dwell + 1'b1;
      end
    end

    if (evt_valid && evt_ready) begin
      evt_valid_d = 1'b0;
    end

    // A commit always wins over a transfer on the same edge
    if (commit) begin
      stage_d       = commit_to;
      evt_valid_d   = 1'b1;
      evt_from_d    = stage;
      evt_to_d      = commit_to;
      evt_advance_d = (commit_to > stage);
      if (evt_valid && !evt_ready) begin
        evt_overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage       <= 2'd0;
      dwell       <= '0;
      evt_valid   <= 1'b0;
      evt_advance <= 1'b0;
      evt_from    <= 2'd0;
      evt_to      <= 2'd0;
      evt_overrun <= 1'b0;
    end else begin
      stage       <= stage_d;
      dwell       <= dwell_d;
      evt_valid   <= evt_valid_d;
      evt_advance <= evt_advance_d;
      evt_from    <= evt_from_d;
      evt_to      <= evt_to_d;
      evt_overrun <= evt_overrun_d;
    end
  end

endmodule

// File: tb/tb_development_stage_tracker.sv
// Directed bench for development_stage_tracker: debounce, dwell, event
// handshake with overrun, tick gating and asynchronous reset.
module tb_development_stage_tracker;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [1:0] development_stage;
  logic       evt_ready;

  logic [1:0] stage;
  logic [7:0] dwell;
  logic       evt_valid, evt_advance, evt_overrun;
  logic [1:0] evt_from, evt_to;

  logic [1:0] w4_stage;
  logic [3:0] w4_dwell;
  logic       w4_evt_valid, w4_evt_advance, w4_evt_overrun;
  logic [1:0] w4_evt_from, w4_evt_to;

  int n_tests = 0;
  int n_fail  = 0;

  development_stage_tracker #(.CONFIRM_TICKS(4), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .development_stage(development_stage), .evt_ready(evt_ready),
    .stage(stage), .dwell(dwell), .evt_valid(evt_valid),
    .evt_advance(evt_advance), .evt_from(evt_from), .evt_to(evt_to),
    .evt_overrun(evt_overrun)
  );

  development_stage_tracker #(.CONFIRM_TICKS(4), .DWELL_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .development_stage(development_stage), .evt_ready(evt_ready),
    .stage(w4_stage), .dwell(w4_dwell), .evt_valid(w4_evt_valid),
    .evt_advance(w4_evt_advance), .evt_from(w4_evt_from), .evt_to(w4_evt_to),
    .evt_overrun(w4_evt_overrun)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_evt(input string tag, input logic v, input logic adv,
                           input logic [1:0] from, input logic [1:0] to);
    check({tag, ".valid"},   32'(evt_valid),   32'(v));
    check({tag, ".advance"}, 32'(evt_advance), 32'(adv));
    check({tag, ".from"},    32'(evt_from),    32'(from));
    check({tag, ".to"},      32'(evt_to),      32'(to));
  endtask

  task automatic check_sd(input string tag, input logic [1:0] s, input logic [7:0] d);
    check({tag, ".stage"}, 32'(stage), 32'(s));
    check({tag, ".dwell"}, 32'(dwell), 32'(d));
  endtask

  // Drivers
  task automatic do_tick(input logic [1:0] v);
    development_stage = v;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic do_ticks(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) do_tick(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    tick = 1'b0;
    development_stage = 2'd0;
    evt_ready = 1'b0;
    #12;
    check_sd("reset", 2'd0, 8'd0);
    check_evt("reset", 1'b0, 1'b0, 2'd0, 2'd0);
    check("reset.overrun", 32'(evt_overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Steady input: dwell counts ticks, narrow dwell saturates
    do_ticks(2'd0, 20);
    check_sd("steady20", 2'd0, 8'd20);
    check("steady20.valid", 32'(evt_valid), 32'd0);
    check("w4.sat20", 32'(w4_dwell), 32'd15);
    do_ticks(2'd0, 10);
    check_sd("steady30", 2'd0, 8'd30);
    check("w4.sat30", 32'(w4_dwell), 32'd15);

    // 0 -> 1 held, consumer ready
    evt_ready = 1'b1;
    do_ticks(2'd1, 3);
    check_sd("confirm3", 2'd0, 8'd33);
    check("confirm3.valid", 32'(evt_valid), 32'd0);
    do_tick(2'd1);
    check_sd("commit01", 2'd1, 8'd0);
    check_evt("commit01", 1'b1, 1'b1, 2'd0, 2'd1);
    idle(1);
    check("commit01.one_cycle", 32'(evt_valid), 32'd0);
    check("commit01.overrun", 32'(evt_overrun), 32'd0);

    // Back to 0, then jitter 1,1,1,0 must abort
    do_ticks(2'd0, 4);
    check_sd("commit10", 2'd0, 8'd0);
    check_evt("commit10", 1'b1, 1'b0, 2'd1, 2'd0);
    idle(1);
    do_tick(2'd1); do_tick(2'd1); do_tick(2'd1); do_tick(2'd0);
    check_sd("jitter", 2'd0, 8'd4);
    check("jitter.valid", 32'(evt_valid), 32'd0);
    do_ticks(2'd1, 3);
    check_sd("reconfirm3", 2'd0, 8'd7);
    do_tick(2'd1);
    check_sd("reconfirm4", 2'd1, 8'd0);
    check_evt("reconfirm4", 1'b1, 1'b1, 2'd0, 2'd1);

    // Pending event held stable, then transfer and commit on the same edge
    evt_ready = 1'b0;
    do_ticks(2'd2, 3);
    check_evt("held", 1'b1, 1'b1, 2'd0, 2'd1);
    check_sd("held", 2'd1, 8'd3);
    evt_ready = 1'b1;
    do_tick(2'd2);
    check_evt("xfer_commit", 1'b1, 1'b1, 2'd1, 2'd2);
    check("xfer_commit.overrun", 32'(evt_overrun), 32'd0);
    idle(1);
    check("xfer_commit.clear", 32'(evt_valid), 32'd0);

    // Stage 2 -> 1 unaccepted, then overwritten by 1 -> 3
    evt_ready = 1'b0;
    do_ticks(2'd1, 4);
    check_evt("down21", 1'b1, 1'b0, 2'd2, 2'd1);
    check("down21.overrun", 32'(evt_overrun), 32'd0);
    do_ticks(2'd3, 2);
    check_evt("pending", 1'b1, 1'b0, 2'd2, 2'd1);
    do_ticks(2'd3, 2);
    check_evt("overwrite", 1'b1, 1'b1, 2'd1, 2'd3);
    check("overwrite.overrun", 32'(evt_overrun), 32'd1);
    check_sd("overwrite", 2'd3, 8'd0);
    evt_ready = 1'b1;
    idle(1);
    check("drain.valid", 32'(evt_valid), 32'd0);
    check("drain.overrun", 32'(evt_overrun), 32'd1);

    // tick=0 with a differing input changes nothing
    do_ticks(2'd3, 5);
    development_stage = 2'd0;
    idle(50);
    check_sd("no_tick", 2'd3, 8'd5);
    check("no_tick.valid", 32'(evt_valid), 32'd0);

    // Asynchronous reset mid-confirmation
    do_ticks(2'd0, 2);
    check_sd("mid_confirm", 2'd3, 8'd7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_sd("async_rst", 2'd0, 8'd0);
    check_evt("async_rst", 1'b0, 1'b0, 2'd0, 2'd0);
    check("async_rst.overrun", 32'(evt_overrun), 32'd0);
    check("async_rst.w4_dwell", 32'(w4_dwell), 32'd0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // No leftover candidate after reset
    do_ticks(2'd0, 3);
    check_sd("post_rst", 2'd0, 8'd3);
    check("post_rst.valid", 32'(evt_valid), 32'd0);
    do_ticks(2'd2, 3);
    check("post_rst.confirm3", 32'(stage), 32'd0);
    do_tick(2'd2);
    check_evt("post_rst.commit", 1'b1, 1'b1, 2'd0, 2'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
